ext_mem_arbiter: RTL

- Shares the single external memory (one read port, one write port) between NB_REQ requesters, e.g. controller partial-sum reads, MAC writeback and a host loader.
- Read and write ports are arbitrated independently, each with its own round-robin pointer; at most one read grant and one write grant per cycle.
- Memory-side outputs are registered.
- Read data returns on a shared response bus tagged with the requester id.

---
 rtl/ext_mem_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ext_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_arbiter
// Description : Shares one external memory between NB_REQ requesters. Read and
//               write ports each have a round-robin arbiter. Memory-side
//               outputs are registered. Read data returns tagged by id.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_mem_arbiter #(
    parameter int NB_REQ       = 3,
    parameter int ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           rst_in,
    input  logic [NB_REQ-1:0]              req_valid,
    input  logic [NB_REQ-1:0]              req_we,
    input  logic [NB_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NB_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NB_REQ-1:0]              req_ready,
    output logic [ADDR_WIDTH-1:0]          ext_mem_read_addr,
    output logic                           ext_mem_read_en,
    input  logic [DATA_WIDTH-1:0]          ext_mem_qout,
    output logic [ADDR_WIDTH-1:0]          ext_mem_write_addr,
    output logic [DATA_WIDTH-1:0]          ext_mem_din,
    output logic                           ext_mem_write_en,
    output logic                           rsp_valid,
    output logic [$clog2(NB_REQ)-1:0]      rsp_id,
    output logic [DATA_WIDTH-1:0]          rsp_data
);

    localparam int c_ID_W = $clog2(NB_REQ);

    // Returns {found, index} of the first candidate at or after ptr, wrapping.
    function automatic logic [c_ID_W:0] f_rr_pick(
        input logic [NB_REQ-1:0] cand,
        input logic [c_ID_W-1:0] ptr
    );
        logic              found;
        logic [c_ID_W-1:0] pick;
        int                idx;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            idx = (int'(ptr) + k) % NB_REQ;
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = c_ID_W'(idx);
            end
        end
        return {found, pick};
    endfunction

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NB_REQ-1:0]     w_rd_cand;
    logic [NB_REQ-1:0]     w_wr_cand;
    logic [c_ID_W-1:0]     r_rd_ptr_q;
    logic [c_ID_W-1:0]     w_rd_ptr_d;
    logic [c_ID_W-1:0]     r_wr_ptr_q;
    logic [c_ID_W-1:0]     w_wr_ptr_d;
    logic                  w_rd_found;
    logic                  w_wr_found;
    logic [c_ID_W-1:0]     w_rd_gnt_idx;
    logic [c_ID_W-1:0]     w_wr_gnt_idx;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_raw_hazard;
    logic                  w_rd_go;
    logic                  w_wr_go;
    logic [NB_REQ-1:0]     w_ready;

    assign w_rd_cand = req_valid & ~req_we;
    assign w_wr_cand = req_valid &  req_we;

    always_comb begin
        {w_rd_found, w_rd_gnt_idx} = f_rr_pick(w_rd_cand, r_rd_ptr_q);
        {w_wr_found, w_wr_gnt_idx} = f_rr_pick(w_wr_cand, r_wr_ptr_q);
        w_rd_addr = req_addr[int'(w_rd_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        w_wr_addr = req_addr[int'(w_wr_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        w_wr_data = req_wdata[int'(w_wr_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    // A same-address read yields to the write so it observes the new data.
    assign w_raw_hazard = w_rd_found && w_wr_found && (w_rd_addr == w_wr_addr);
    assign w_rd_go      = w_rd_found && !w_raw_hazard && !rst_in;
    assign w_wr_go      = w_wr_found && !rst_in;

    always_comb begin
        w_ready = '0;
        if (w_rd_go) begin
            w_ready[w_rd_gnt_idx] = 1'b1;
        end
        if (w_wr_go) begin
            w_ready[w_wr_gnt_idx] = 1'b1;
        end
    end

    assign req_ready = w_ready;

    always_comb begin
        w_rd_ptr_d = r_rd_ptr_q;
        w_wr_ptr_d = r_wr_ptr_q;
        if (w_rd_go) begin
            w_rd_ptr_d = c_ID_W'((int'(w_rd_gnt_idx) + 1) % NB_REQ);
        end
        if (w_wr_go) begin
            w_wr_ptr_d = c_ID_W'((int'(w_wr_gnt_idx) + 1) % NB_REQ);
        end
    end

    // ------------------------------------------------------------------
    // Issue registers
    // ------------------------------------------------------------------
    logic                  r_read_en_q;
    logic                  w_read_en_d;
    logic [ADDR_WIDTH-1:0] r_read_addr_q;
    logic [ADDR_WIDTH-1:0] w_read_addr_d;
    logic [c_ID_W-1:0]     r_rd_id_q;
    logic [c_ID_W-1:0]     w_rd_id_d;
    logic                  r_write_en_q;
    logic                  w_write_en_d;
    logic [ADDR_WIDTH-1:0] r_write_addr_q;
    logic [ADDR_WIDTH-1:0] w_write_addr_d;
    logic [DATA_WIDTH-1:0] r_din_q;
    logic [DATA_WIDTH-1:0] w_din_d;

    always_comb begin
        w_read_en_d    = w_rd_go;
        w_read_addr_d  = r_read_addr_q;
        w_rd_id_d      = r_rd_id_q;
        w_write_en_d   = w_wr_go;
        w_write_addr_d = r_write_addr_q;
        w_din_d        = r_din_q;
        if (w_rd_go) begin
            w_read_addr_d = w_rd_addr;
            w_rd_id_d     = w_rd_gnt_idx;
        end
        if (w_wr_go) begin
            w_write_addr_d = w_wr_addr;
            w_din_d        = w_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Response tag pipeline, aligned with the memory read latency
    // ------------------------------------------------------------------
    logic              r_pipe_vld_q [READ_LATENCY];
    logic              w_pipe_vld_d [READ_LATENCY];
    logic [c_ID_W-1:0] r_pipe_id_q  [READ_LATENCY];
    logic [c_ID_W-1:0] w_pipe_id_d  [READ_LATENCY];

    always_comb begin
        w_pipe_vld_d[0] = r_read_en_q;
        w_pipe_id_d[0]  = r_rd_id_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            w_pipe_vld_d[i] = r_pipe_vld_q[i-1];
            w_pipe_id_d[i]  = r_pipe_id_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_rd_ptr_q     <= '0;
            r_wr_ptr_q     <= '0;
            r_read_en_q    <= 1'b0;
            r_read_addr_q  <= '0;
            r_rd_id_q      <= '0;
            r_write_en_q   <= 1'b0;
            r_write_addr_q <= '0;
            r_din_q        <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_vld_q[i] <= 1'b0;
                r_pipe_id_q[i]  <= '0;
            end
        end else begin
            r_rd_ptr_q     <= w_rd_ptr_d;
            r_wr_ptr_q     <= w_wr_ptr_d;
            r_read_en_q    <= w_read_en_d;
            r_read_addr_q  <= w_read_addr_d;
            r_rd_id_q      <= w_rd_id_d;
            r_write_en_q   <= w_write_en_d;
            r_write_addr_q <= w_write_addr_d;
            r_din_q        <= w_din_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_vld_q[i] <= w_pipe_vld_d[i];
                r_pipe_id_q[i]  <= w_pipe_id_d[i];
            end
        end
    end

    assign ext_mem_read_en    = r_read_en_q;
    assign ext_mem_read_addr  = r_read_addr_q;
    assign ext_mem_write_en   = r_write_en_q;
    assign ext_mem_write_addr = r_write_addr_q;
    assign ext_mem_din        = r_din_q;
    assign rsp_valid          = r_pipe_vld_q[READ_LATENCY-1];
    assign rsp_id             = r_pipe_id_q[READ_LATENCY-1];
    assign rsp_data           = ext_mem_qout;

endmodule
`default_nettype wire
